adrv9001_rx_serdes_phase_track: RTL and testbench

Parametrised strobe-phase tracker for the ADRV9001 RX SERDES path. It decodes the position of the single strobe pulse in each deserialised strobe word and rejects malformed words. It qualifies the phase with a lock/unlock hysteresis state machine and counts strobe errors. The result feeds the RX word-alignment barrel shifter, which must only act on a locked, stable phase.

---
 rtl/adrv9001_rx_serdes_phase_track_pkg.sv | 17 +
 rtl/adrv9001_rx_serdes_phase_track_strb_decode.sv | 75 +++++++
 rtl/adrv9001_rx_serdes_phase_track.sv | 179 +++++++++++++++++
 tb/tb_adrv9001_rx_serdes_phase_track.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adrv9001_rx_serdes_phase_track_pkg.sv
// Shared definitions for the ADRV9001 RX strobe-phase tracker.
//   track_state_e : phase-tracking FSM encoding (SEARCH=0, CONFIRM=1, LOCKED=2, HOLD=3)
//   ERR_W         : width of the saturating strobe error counter
//   CNT_W         : width of the lock/unlock qualification counters
package adrv9001_rx_serdes_phase_track_pkg;

  localparam int ERR_W = 16;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HOLD    = 2'd3
  } track_state_e;

endpackage

// File: rtl/adrv9001_rx_serdes_phase_track_strb_decode.sv
// Stage 1 of the strobe-phase tracker: registered one-hot check and
// MSB-first position encoder for one deserialised strobe word.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   strb_valid  : qualifies strb for this cycle
//   strb        : strobe word, strb[WIDTH-1] is earliest in time
//   valid       : registered copy of strb_valid (clears on idle cycles)
//   good / bad  : word had exactly one bit set / did not
//   p           : position of the set bit counted from the MSB
module adrv9001_strb_decode
  import adrv9001_rx_serdes_phase_track_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int PW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strb_valid,
  input  logic [WIDTH-1:0] strb,
  output logic             valid,
  output logic             good,
  output logic             bad,
  output logic [PW-1:0]    p
);

  logic          one_hot;
  logic [PW-1:0] pos;
  logic          valid_d, valid_q;
  logic          good_d, good_q;
  logic          bad_d, bad_q;
  logic [PW-1:0] p_d, p_q;

  // Clearing the lowest set bit leaves zero only for a single-bit word.
  // The position scan keeps the highest set bit; it only matters when one-hot.
  always_comb begin
    one_hot = (strb != '0) && ((strb & (strb - WIDTH'(1))) == '0);
    pos     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (strb[i]) pos = PW'(WIDTH - 1 - i);
    end
  end

  // Decode fields hold their last value on idle cycles; only valid drops.
  always_comb begin
    valid_d = strb_valid;
    good_d  = good_q;
    bad_d   = bad_q;
    p_d     = p_q;
    if (strb_valid) begin
      good_d = one_hot;
      bad_d  = !one_hot;
      p_d    = pos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      valid_q <= valid_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      p_q     <= p_d;
    end
  end

  assign valid = valid_q;
  assign good  = good_q;
  assign bad   = bad_q;
  assign p     = p_q;

endmodule

// File: rtl/adrv9001_rx_serdes_phase_track.sv
// Strobe-phase tracker for the ADRV9001 RX SERDES path. Decodes the strobe
// position of each word, qualifies it with lock/unlock hysteresis and counts
// strobe errors. Downstream word alignment must only act while phase_valid.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   strb_valid   : strb qualifier; there is no back-pressure, every cycle with
//                  strb_valid=1 delivers exactly one word, idle cycles are ignored
//   strb         : deserialised strobe word, MSB first in time
//   err_clr      : clears err_cnt (wins over a coincident error)
//   phase        : locked phase offset counted from the MSB
//   phase_valid  : high while locked (LOCKED or HOLD)
//   locked       : same as phase_valid, for the status register
//   lock_lost    : one-cycle pulse when lock drops
//   err_cnt      : saturating strobe error count
//   dbg_state    : current FSM state (track_state_e encoding)
module adrv9001_rx_serdes_phase_track
  import adrv9001_rx_serdes_phase_track_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int LOCK_CNT   = 8,
  parameter  int UNLOCK_CNT = 4,
  localparam int PW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strb_valid,
  input  logic [WIDTH-1:0] strb,
  input  logic             err_clr,
  output logic [PW-1:0]    phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  logic          s1_valid, s1_good, s1_bad;
  logic [PW-1:0] s1_p;

  adrv9001_strb_decode #(.WIDTH(WIDTH)) u_decode (
    .clk        (clk),
    .rst        (rst),
    .strb_valid (strb_valid),
    .strb       (strb),
    .valid      (s1_valid),
    .good       (s1_good),
    .bad        (s1_bad),
    .p          (s1_p)
  );

  track_state_e     state_d, state_q;
  logic [PW-1:0]    cand_d, cand_q;
  logic [PW-1:0]    phase_d, phase_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] miss_d, miss_q;
  logic             lock_lost_d, lock_lost_q;
  logic [ERR_W-1:0] err_d, err_q;
  logic             err_ev;
  logic             match_phase;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    lock_lost_d = 1'b0;
    err_ev      = 1'b0;
    match_phase = s1_good && (s1_p == phase_q);

    if (s1_valid) begin
      err_ev = s1_bad;
      case (state_q)
        ST_SEARCH: begin
          if (s1_good) begin
            if (LOCK_CNT == 1) begin
              state_d = ST_LOCKED;
              phase_d = s1_p;
              cnt_d   = '0;
              miss_d  = '0;
            end else begin
              state_d = ST_CONFIRM;
              cand_d  = s1_p;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_CONFIRM: begin
          if (s1_bad) begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
          end else if (s1_p == cand_q) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              phase_d = cand_q;
              cnt_d   = '0;
              miss_d  = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            // A different good phase restarts qualification from this word.
            cand_d = s1_p;
            cnt_d  = CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (match_phase) begin
            miss_d = '0;
          end else begin
            err_ev = 1'b1;
            if (UNLOCK_CNT == 1) begin
              state_d     = ST_SEARCH;
              lock_lost_d = 1'b1;
              miss_d      = '0;
            end else begin
              state_d = ST_HOLD;
              miss_d  = CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (match_phase) begin
            state_d = ST_LOCKED;
            miss_d  = '0;
          end else begin
            err_ev = 1'b1;
            if (miss_q + CNT_W'(1) == CNT_W'(UNLOCK_CNT)) begin
              // phase is deliberately left at its last locked value.
              state_d     = ST_SEARCH;
              lock_lost_d = 1'b1;
              miss_d      = '0;
              cnt_d       = '0;
            end else begin
              miss_d = miss_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (err_ev && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      cand_q      <= '0;
      phase_q     <= '0;
      cnt_q       <= '0;
      miss_q      <= '0;
      lock_lost_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      lock_lost_q <= lock_lost_d;
      err_q       <= err_d;
    end
  end

  // HOLD still counts as locked: the phase is trusted until misses run out.
  assign locked      = (state_q == ST_LOCKED) || (state_q == ST_HOLD);
  assign phase_valid = locked;
  assign phase       = phase_q;
  assign lock_lost   = lock_lost_q;
  assign err_cnt     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_adrv9001_rx_serdes_phase_track.sv
module tb_adrv9001_rx_serdes_phase_track;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: WIDTH=16, LOCK_CNT=8, UNLOCK_CNT=4
  logic        a_valid, a_clr;
  logic [15:0] a_strb;
  logic [3:0]  a_phase;
  logic        a_phase_valid, a_locked, a_lock_lost;
  logic [15:0] a_err;
  logic [1:0]  a_dbg;

  // DUT B: WIDTH=8, LOCK_CNT=1, UNLOCK_CNT=1
  logic        b_valid, b_clr;
  logic [7:0]  b_strb;
  logic [2:0]  b_phase;
  logic        b_phase_valid, b_locked, b_lock_lost;
  logic [15:0] b_err;
  logic [1:0]  b_dbg;

  adrv9001_rx_serdes_phase_track #(.WIDTH(16), .LOCK_CNT(8), .UNLOCK_CNT(4)) dut_a (
    .clk(clk), .rst(rst), .strb_valid(a_valid), .strb(a_strb), .err_clr(a_clr),
    .phase(a_phase), .phase_valid(a_phase_valid), .locked(a_locked),
    .lock_lost(a_lock_lost), .err_cnt(a_err), .dbg_state(a_dbg)
  );

  adrv9001_rx_serdes_phase_track #(.WIDTH(8), .LOCK_CNT(1), .UNLOCK_CNT(1)) dut_b (
    .clk(clk), .rst(rst), .strb_valid(b_valid), .strb(b_strb), .err_clr(b_clr),
    .phase(b_phase), .phase_valid(b_phase_valid), .locked(b_locked),
    .lock_lost(b_lock_lost), .err_cnt(b_err), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b1;

  // Words sampled by each DUT but not yet acted on ({valid, word}).
  logic [32:0] exp_q[2][$];

  // Reference model: tracks the run of identical good phases while unlocked
  // and the run of misses while locked.
  int m_width [2] = '{16, 8};
  int m_lockn [2] = '{8, 1};
  int m_unlckn[2] = '{4, 1};
  bit m_locked[2];
  bit m_lost  [2];
  int m_phase [2];
  int m_run_p [2];
  int m_run_n [2];
  int m_miss  [2];
  int m_err   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_locked[id] = 0; m_lost[id] = 0; m_phase[id] = 0; m_run_p[id] = 0;
      m_run_n[id] = 0; m_miss[id] = 0; m_err[id] = 0;
      exp_q[id].delete();
      exp_q[id].push_back('0);
    end
  endtask

  // One clock edge of the model: act on the word sampled one edge earlier.
  task automatic model_edge(input int id, input logic [32:0] ent, input bit clr);
    bit ev, good;
    int p, ones, idx;
    logic [31:0] w;
    ev = 0;
    m_lost[id] = 0;
    w = ent[31:0];
    if (ent[32]) begin
      ones = 0; idx = 0;
      for (int i = 0; i < m_width[id]; i++) if (w[i]) begin ones++; idx = i; end
      good = (ones == 1);
      p = m_width[id] - 1 - idx;
      if (!m_locked[id]) begin
        if (!good) begin
          ev = 1;
          m_run_n[id] = 0;
        end else begin
          if (m_run_n[id] > 0 && p == m_run_p[id]) m_run_n[id]++;
          else begin m_run_p[id] = p; m_run_n[id] = 1; end
          if (m_run_n[id] == m_lockn[id]) begin
            m_locked[id] = 1; m_phase[id] = p; m_run_n[id] = 0; m_miss[id] = 0;
          end
        end
      end else begin
        if (good && p == m_phase[id]) m_miss[id] = 0;
        else begin
          ev = 1;
          m_miss[id]++;
          if (m_miss[id] == m_unlckn[id]) begin
            m_locked[id] = 0; m_lost[id] = 1; m_miss[id] = 0; m_run_n[id] = 0;
          end
        end
      end
    end
    if (clr) m_err[id] = 0;
    else if (ev && m_err[id] < 65535) m_err[id]++;
  endtask

  task automatic compare_all();
    check("a_locked", a_locked, m_locked[0]);
    check("a_phase_valid", a_phase_valid, m_locked[0]);
    check("a_phase", a_phase, m_phase[0]);
    check("a_lock_lost", a_lock_lost, m_lost[0]);
    check("a_err_cnt", a_err, m_err[0]);
    check("b_locked", b_locked, m_locked[1]);
    check("b_phase_valid", b_phase_valid, m_locked[1]);
    check("b_phase", b_phase, m_phase[1]);
    check("b_lock_lost", b_lock_lost, m_lost[1]);
    check("b_err_cnt", b_err, m_err[1]);
  endtask

  // ---------------- driver tasks (entered and left at negedge) ----------------
  task automatic tick(input bit av, input logic [15:0] aw, input bit ac,
                      input bit bv, input logic [7:0] bw, input bit bc);
    logic [32:0] ent;
    a_valid = av; a_strb = aw; a_clr = ac;
    b_valid = bv; b_strb = bw; b_clr = bc;
    @(posedge clk);
    ent = exp_q[0].pop_front(); model_edge(0, ent, ac);
    exp_q[0].push_back({av, 16'h0, aw});
    ent = exp_q[1].pop_front(); model_edge(1, ent, bc);
    exp_q[1].push_back({bv, 24'h0, bw});
    @(negedge clk);
    if (chk_en) compare_all();
  endtask

  task automatic tick_a(input bit v, input logic [15:0] w, input bit c);
    tick(v, w, c, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic tick_b(input bit v, input logic [7:0] w, input bit c);
    tick(1'b0, 16'h0000, 1'b0, v, w, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 0; a_strb = '0; a_clr = 0;
    b_valid = 0; b_strb = '0; b_clr = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_word(input int width, input logic [15:0] fav);
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return fav;
    if (r < 8) return 16'(1) << $urandom_range(0, width - 1);
    if (r == 8) return 16'h0000;
    return 16'($urandom_range(0, 65535)) & 16'((1 << width) - 1);
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] fav_a, fav_b;
    do_reset();
    check("rst_locked", a_locked, 1'b0);
    check("rst_phase", a_phase, 4'd0);
    check("rst_lock_lost", a_lock_lost, 1'b0);
    check("rst_err", a_err, 16'd0);
    check("rst_state", a_dbg, 2'd0);

    // Lock on phase 5: locked rises the edge after the 8th word is sampled.
    repeat (8) tick_a(1, 16'h0400, 0);
    check("lock_not_yet", a_locked, 1'b0);
    tick_a(0, 16'h0000, 0);
    check("lock_rise", a_locked, 1'b1);
    check("lock_phase5", a_phase, 4'd5);
    check("lock_err0", a_err, 16'd0);

    // Three bad words ride through HOLD without losing lock.
    repeat (3) tick_a(1, 16'h0000, 0);
    tick_a(1, 16'h0400, 0);
    tick_a(0, 16'h0000, 0);
    check("hold_still_locked", a_locked, 1'b1);
    check("hold_err3", a_err, 16'd3);

    // Idle gaps with garbage on strb change nothing.
    repeat (5) tick_a(0, 16'hFFFF, 0);
    check("gap_locked", a_locked, 1'b1);

    // Four mismatching words drop lock, then relock on phase 10.
    tick_a(0, 16'h0000, 1);
    repeat (4) tick_a(1, 16'h0020, 0);
    tick_a(0, 16'h0000, 0);
    check("unlock_pulse", a_lock_lost, 1'b1);
    check("unlock_locked0", a_locked, 1'b0);
    check("unlock_pv0", a_phase_valid, 1'b0);
    check("unlock_phase_hold", a_phase, 4'd5);
    check("unlock_err4", a_err, 16'd4);
    tick_a(0, 16'h0000, 0);
    check("unlock_pulse_end", a_lock_lost, 1'b0);
    repeat (8) tick_a(1, 16'h0020, 0);
    tick_a(0, 16'h0000, 0);
    check("relock_phase10", a_phase, 4'd10);
    check("relock_locked", a_locked, 1'b1);

    // Mid-operation reset returns everything to reset values.
    repeat (2) tick_a(1, 16'h0000, 0);
    do_reset();
    check("midrst_locked", a_locked, 1'b0);
    check("midrst_phase", a_phase, 4'd0);
    check("midrst_err", a_err, 16'd0);
    check("midrst_state", a_dbg, 2'd0);

    // Candidate restart in CONFIRM.
    repeat (5) tick_a(1, 16'h8000, 0);
    repeat (8) tick_a(1, 16'h4000, 0);
    check("cand_not_yet", a_locked, 1'b0);
    tick_a(1, 16'h4000, 0);
    tick_a(0, 16'h0000, 0);
    check("cand_locked", a_locked, 1'b1);
    check("cand_phase1", a_phase, 4'd1);

    // A multi-bit word in CONFIRM restarts qualification.
    do_reset();
    repeat (3) tick_a(1, 16'h8000, 0);
    tick_a(1, 16'h8001, 0);
    repeat (7) tick_a(1, 16'h8000, 0);
    tick_a(0, 16'h0000, 0);
    check("multibit_no_lock", a_locked, 1'b0);
    check("multibit_err1", a_err, 16'd1);
    tick_a(1, 16'h8000, 0);
    tick_a(0, 16'h0000, 0);
    check("multibit_relock", a_locked, 1'b1);
    check("multibit_phase0", a_phase, 4'd0);

    // Single-word lock/unlock on the narrow instance.
    tick_b(1, 8'h01, 0);
    tick_b(0, 8'h00, 0);
    check("b_lock", b_locked, 1'b1);
    check("b_phase7", b_phase, 3'd7);
    tick_b(1, 8'h03, 0);
    tick_b(0, 8'h00, 0);
    check("b_lost_pulse", b_lock_lost, 1'b1);
    check("b_unlocked", b_locked, 1'b0);
    check("b_err1", b_err, 16'd1);

    // Error counter saturation and clear priority.
    do_reset();
    chk_en = 1'b0;
    repeat (65540) tick_a(1, 16'h0000, 0);
    chk_en = 1'b1;
    tick_a(0, 16'h0000, 0);
    check("err_saturate", a_err, 16'hFFFF);
    tick_a(1, 16'h0000, 1);
    tick_a(0, 16'h0000, 1);
    tick_a(0, 16'h0000, 0);
    check("err_clear_wins", a_err, 16'd0);

    // Randomized traffic on both instances against the model.
    do_reset();
    fav_a = 16'(1) << $urandom_range(0, 15);
    fav_b = 16'(1) << $urandom_range(0, 7);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) fav_a = 16'(1) << $urandom_range(0, 15);
      if ($urandom_range(0, 199) == 0) fav_b = 16'(1) << $urandom_range(0, 7);
      tick($urandom_range(0, 9) != 0, rand_word(16, fav_a), $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) != 0, 8'(rand_word(8, fav_b)), $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
